// File: rtl/led_pattern_arbiter.sv
// Round-robin arbiter that shares one LED (mirrored on PIN_1) between NUM_REQ pattern sources.
// The winner's captured pattern is played LSB-first, one bit per TICK_DIV clocks, then a dark gap.
module led_pattern_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PATTERN_W = 32,
    parameter int unsigned TICK_DIV  = 2097152,
    parameter int unsigned GAP_TICKS = 2,
    localparam int unsigned LW       = $clog2(PATTERN_W)
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [NUM_REQ-1:0]           REQ,
    input  logic [NUM_REQ*PATTERN_W-1:0] REQ_PATTERN,
    input  logic [NUM_REQ*LW-1:0]        REQ_LEN,
    input  logic                         ABORT,
    output logic [NUM_REQ-1:0]           GRANT,
    output logic [NUM_REQ-1:0]           DONE,
    output logic                         BUSY,
    output logic                         LED,
    output logic                         PIN_1
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GapLast  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          rr_q, rr_d;
    logic [PW-1:0]          win_q, win_d;
    logic [PATTERN_W-1:0]   pat_q, pat_d;
    logic [LW-1:0]          len_q, len_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [LW-1:0]          bit_q, bit_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   led_q, led_d;

    logic                   found;
    logic [PW-1:0]          pick;
    logic [PW-1:0]          cand;
    logic [PATTERN_W-1:0]   pat_sel;
    logic [LW-1:0]          len_sel;
    logic [LW-1:0]          bit_nxt;

    // First pending requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PW'((32'(rr_q) + i) % NUM_REQ);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pat_sel = REQ_PATTERN[32'(pick) * PATTERN_W +: PATTERN_W];
        len_sel = REQ_LEN[32'(pick) * LW +: LW];
    end

    assign bit_nxt = bit_q + 1'b1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        grant_d = grant_q;
        done_d  = '0;
        led_d   = led_q;

        unique case (state_q)
            StIdle: begin
                led_d   = 1'b0;
                grant_d = '0;
                if (found) begin
                    state_d       = StPlay;
                    win_d         = pick;
                    rr_d          = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    pat_d         = pat_sel;
                    len_d         = len_sel;
                    tick_d        = '0;
                    bit_d         = '0;
                    grant_d[pick] = 1'b1;
                    led_d         = pat_sel[0];
                end
            end
            StPlay: begin
                if (ABORT) begin
                    state_d = StIdle;
                    grant_d = '0;
                    led_d   = 1'b0;
                    tick_d  = '0;
                    bit_d   = '0;
                end else if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (bit_q == len_q) begin
                        grant_d       = '0;
                        led_d         = 1'b0;
                        done_d[win_q] = 1'b1;
                        bit_d         = '0;
                        gap_d         = '0;
                        state_d       = (GAP_TICKS > 0) ? StGap : StIdle;
                    end else begin
                        bit_d = bit_nxt;
                        led_d = pat_q[bit_nxt];
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StGap: begin
                led_d   = 1'b0;
                grant_d = '0;
                if (ABORT) begin
                    state_d = StIdle;
                    tick_d  = '0;
                    gap_d   = '0;
                end else if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (gap_q == GapLast) begin
                        state_d = StIdle;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                led_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            rr_q    <= '0;
            win_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign GRANT = grant_q;
    assign DONE  = done_q;
    assign BUSY  = busy_q;
    assign LED   = led_q;
    assign PIN_1 = led_q;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed bench for led_pattern_arbiter: table-driven playbacks plus reset, round-robin
// and abort sequences, with TICK_DIV=4 and GAP_TICKS=1.
module tb_led_pattern_arbiter;

    localparam int NR = 4;
    localparam int PWD = 32;
    localparam int LWD = 5;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic [NR-1:0]   REQ = '0;
    logic [NR*PWD-1:0] REQ_PATTERN = '0;
    logic [NR*LWD-1:0] REQ_LEN = '0;
    logic            ABORT = 1'b0;
    logic [NR-1:0]   GRANT;
    logic [NR-1:0]   DONE;
    logic            BUSY;
    logic            LED;
    logic            PIN_1;

    int n_vec = 0;
    int n_bad = 0;

    led_pattern_arbiter #(
        .NUM_REQ  (4),
        .PATTERN_W(32),
        .TICK_DIV (4),
        .GAP_TICKS(1)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ        (REQ),
        .REQ_PATTERN(REQ_PATTERN),
        .REQ_LEN    (REQ_LEN),
        .ABORT      (ABORT),
        .GRANT      (GRANT),
        .DONE       (DONE),
        .BUSY       (BUSY),
        .LED        (LED),
        .PIN_1      (PIN_1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          r;
        logic [31:0] pat;
        logic [4:0]  len;
        logic [31:0] exp_bits;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Grant, play (LEN+1)*4 cycles, DONE pulse, 4 gap cycles, then IDLE.
    task automatic play(input int r, input logic [31:0] pat, input logic [4:0] len,
                        input logic [31:0] expb);
        logic [NR-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        for (int j = 0; j < NR; j++) begin
            REQ_PATTERN[j*PWD +: PWD] = (j == r) ? pat : ~pat;
            REQ_LEN[j*LWD +: LWD]     = (j == r) ? len : ~len;
        end
        REQ = oh;
        step();
        chk("grant", 32'(GRANT), 32'(oh));
        chk("busy_play", 32'(BUSY), 32'd1);
        // Inputs changing after capture must not disturb playback.
        REQ = '0;
        REQ_PATTERN = ~REQ_PATTERN;
        REQ_LEN = ~REQ_LEN;
        for (int c = 0; c < (int'(len) + 1) * 4; c++) begin
            if (c > 0) step();
            chk("led", 32'(LED), 32'(expb[c/4]));
            chk("pin1", 32'(PIN_1), 32'(expb[c/4]));
            chk("grant_hold", 32'(GRANT), 32'(oh));
            chk("done_early", 32'(DONE), 32'd0);
        end
        step();
        chk("done", 32'(DONE), 32'(oh));
        chk("grant_end", 32'(GRANT), 32'd0);
        chk("led_end", 32'(LED), 32'd0);
        for (int g = 0; g < 3; g++) begin
            step();
            chk("gap_busy", 32'(BUSY), 32'd1);
            chk("gap_led", 32'(LED), 32'd0);
            chk("gap_done", 32'(DONE), 32'd0);
        end
        step();
        chk("idle_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [NR-1:0] exp_oh;

        vecs[0] = '{r: 2, pat: 32'h0000_000B, len: 5'd3,  exp_bits: 32'b1011};
        vecs[1] = '{r: 0, pat: 32'h0000_0001, len: 5'd0,  exp_bits: 32'h1};
        vecs[2] = '{r: 1, pat: 32'h0000_00A5, len: 5'd7,  exp_bits: 32'hA5};
        vecs[3] = '{r: 3, pat: 32'hFFFF_FFFF, len: 5'd31, exp_bits: 32'hFFFF_FFFF};
        vecs[4] = '{r: 1, pat: 32'h8000_0002, len: 5'd31, exp_bits: 32'h8000_0002};
        vecs[5] = '{r: 3, pat: 32'hFFFF_FFF2, len: 5'd1,  exp_bits: 32'b10};

        step();
        step();
        RESET_N = 1'b1;
        step();
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_led", 32'(LED), 32'd0);
        chk("rst_pin1", 32'(PIN_1), 32'd0);

        for (int v = 0; v < 6; v++) begin
            play(vecs[v].r, vecs[v].pat, vecs[v].len, vecs[v].exp_bits);
        end

        // Reset mid-playback, then rr_ptr must be back at 0.
        REQ_PATTERN = '1;
        REQ_LEN = '1;
        REQ = 4'b0010;
        step();
        chk("midrst_grant", 32'(GRANT), 32'b0010);
        REQ = '0;
        for (int k = 0; k < 5; k++) step();
        RESET_N = 1'b0;
        #1;
        chk("midrst_led", 32'(LED), 32'd0);
        chk("midrst_gnt", 32'(GRANT), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        step();
        chk("midrst_done", 32'(DONE), 32'd0);
        RESET_N = 1'b1;
        REQ = 4'b0011;
        step();
        chk("rr_after_rst", 32'(GRANT), 32'b0001);
        REQ = '0;
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_gnt", 32'(GRANT), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);

        // Round robin with all requesters held.
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        for (int j = 0; j < NR; j++) begin
            REQ_PATTERN[j*PWD +: PWD] = 32'h1;
            REQ_LEN[j*LWD +: LWD] = 5'd0;
        end
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = '0;
            exp_oh[k % 4] = 1'b1;
            cnt = 0;
            while (GRANT == 0 && cnt < 20) begin
                step();
                cnt++;
            end
            chk("rr_grant", 32'(GRANT), 32'(exp_oh));
            cnt = 0;
            while (DONE == 0 && cnt < 20) begin
                step();
                chk("rr_onehot0", 32'($onehot0(GRANT)), 32'd1);
                cnt++;
            end
            chk("rr_done", 32'(DONE), 32'(exp_oh));
            if (k == 4) REQ = '0;
            step();
            chk("rr_done_once", 32'(DONE), 32'd0);
        end
        cnt = 0;
        while (BUSY && cnt < 20) begin
            step();
            cnt++;
        end
        chk("rr_idle", 32'(BUSY), 32'd0);

        // ABORT during PLAY cycle 6 of a LEN=7 playback; REQ[3] pending.
        REQ_PATTERN[1*PWD +: PWD] = 32'h0000_00FF;
        REQ_LEN[1*LWD +: LWD] = 5'd7;
        REQ_PATTERN[3*PWD +: PWD] = 32'h1;
        REQ_LEN[3*LWD +: LWD] = 5'd0;
        REQ = 4'b0010;
        step();
        chk("ab_grant", 32'(GRANT), 32'b0010);
        REQ = 4'b1000;
        for (int k = 0; k < 6; k++) step();
        chk("ab_led_c6", 32'(LED), 32'd1);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("ab_gnt", 32'(GRANT), 32'd0);
        chk("ab_led", 32'(LED), 32'd0);
        chk("ab_busy", 32'(BUSY), 32'd0);
        chk("ab_done", 32'(DONE), 32'd0);
        step();
        chk("ab_pending", 32'(GRANT), 32'b1000);
        REQ = '0;

        // ABORT on the final tick beats DONE.
        for (int k = 0; k < 3; k++) step();
        chk("ab_last_led", 32'(LED), 32'd1);
        ABORT = 1'b1;
        step();
        chk("ab_last_done", 32'(DONE), 32'd0);
        chk("ab_last_busy", 32'(BUSY), 32'd0);

        // ABORT held in IDLE is ignored, then takes effect in PLAY.
        REQ_PATTERN[0 +: PWD] = 32'h1;
        REQ_LEN[0 +: LWD] = 5'd0;
        REQ = 4'b0001;
        step();
        chk("ab_idle_grant", 32'(GRANT), 32'b0001);
        REQ = '0;
        step();
        ABORT = 1'b0;
        chk("ab_idle_busy", 32'(BUSY), 32'd0);
        chk("ab_idle_done", 32'(DONE), 32'd0);
        step();
        chk("ab_idle_nodone", 32'(DONE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
